// File: rtl/servo_ramp_seq.sv
// Slew-limited servo sequencer: ramps each servo's position toward its target
// by at most STEP per update tick and writes changed positions to the PWM peripheral.
module servo_ramp_seq #(
    parameter int N_SERVO  = 8,
    parameter int POS_W    = 16,
    parameter int TICK_DIV = 50000,
    parameter int STEP     = 10,
    parameter int POS_MIN  = 50,
    parameter int POS_MAX  = 250,
    parameter int POS_INIT = 150
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_sel,
    input  logic [POS_W-1:0] cmd_pos,
    output logic             cmd_err,
    input  logic             hold,
    output logic             busy,
    output logic             done,
    output logic             pwm_cs,
    output logic             pwm_wr,
    output logic             pwm_rd,
    output logic [7:0]       pwm_addr,
    output logic [31:0]      pwm_d_out
);

    localparam int IDX_W = $clog2(N_SERVO);
    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_SERVO - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [4:0]       SEL_LIM  = 5'(N_SERVO);
    localparam logic [POS_W-1:0] STEP_V   = POS_W'(STEP);
    localparam logic [POS_W-1:0] MIN_V    = POS_W'(POS_MIN);
    localparam logic [POS_W-1:0] MAX_V    = POS_W'(POS_MAX);
    localparam logic [POS_W-1:0] INIT_V   = POS_W'(POS_INIT);

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_SCAN} state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [POS_W-1:0]   cur     [N_SERVO];
    logic [POS_W-1:0]   tgt     [N_SERVO];
    logic [POS_W-1:0]   cur_nxt [N_SERVO];
    logic [POS_W-1:0]   tgt_nxt [N_SERVO];

    logic               tick, accept, sel_ok, err_nxt, busy_nxt, wr_en;
    logic [7:0]         wr_addr;
    logic [POS_W-1:0]   wr_data, clamped;
    logic [POS_W-1:0]   scan_cur, scan_tgt, scan_diff, scan_step, scan_new;

    // Next-state, ramp step and command decode; scan reads registered targets,
    // so a command landing in a servo's scan cycle only takes effect next tick.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cur_nxt   = cur;
        tgt_nxt   = tgt;
        wr_en     = 1'b0;
        wr_addr   = pwm_addr;
        wr_data   = INIT_V;
        busy_nxt  = 1'b0;

        tick    = (cnt == CNT_LAST);
        accept  = cmd_valid && cmd_ready;
        sel_ok  = ({1'b0, cmd_sel} < SEL_LIM);
        err_nxt = accept && !sel_ok;
        clamped = (cmd_pos < MIN_V) ? MIN_V : ((cmd_pos > MAX_V) ? MAX_V : cmd_pos);

        scan_cur  = cur[idx];
        scan_tgt  = tgt[idx];
        scan_diff = (scan_tgt > scan_cur) ? (scan_tgt - scan_cur) : (scan_cur - scan_tgt);
        scan_step = (scan_diff > STEP_V) ? STEP_V : scan_diff;
        scan_new  = (scan_tgt > scan_cur) ? (scan_cur + scan_step) : (scan_cur - scan_step);

        case (state)
            ST_INIT: begin
                wr_en   = 1'b1;
                wr_addr = 8'({idx, 2'b00});
                wr_data = INIT_V;
                if (idx == IDX_LAST) begin
                    state_nxt = ST_IDLE;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end
            ST_IDLE: begin
                if (tick && !hold) begin
                    state_nxt = ST_SCAN;
                    idx_nxt   = '0;
                end
            end
            ST_SCAN: begin
                if (scan_cur != scan_tgt) begin
                    cur_nxt[idx] = scan_new;
                    wr_en        = 1'b1;
                    wr_addr      = 8'({idx, 2'b00});
                    wr_data      = scan_new;
                end
                if (idx == IDX_LAST) begin
                    state_nxt = ST_IDLE;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end
            default: state_nxt = ST_INIT;
        endcase

        if (accept && sel_ok)
            tgt_nxt[cmd_sel[IDX_W-1:0]] = clamped;

        for (int i = 0; i < N_SERVO; i++)
            if (cur_nxt[i] != tgt_nxt[i])
                busy_nxt = 1'b1;
    end

    // State, position registers and registered bus/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_INIT;
            idx       <= '0;
            cnt       <= '0;
            for (int i = 0; i < N_SERVO; i++) begin
                cur[i] <= INIT_V;
                tgt[i] <= INIT_V;
            end
            pwm_cs    <= 1'b0;
            pwm_wr    <= 1'b0;
            pwm_rd    <= 1'b0;
            pwm_addr  <= '0;
            pwm_d_out <= '0;
            cmd_err   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cmd_ready <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            cnt       <= (state == ST_INIT || tick) ? '0 : cnt + 1'b1;
            cur       <= cur_nxt;
            tgt       <= tgt_nxt;
            pwm_cs    <= wr_en;
            pwm_wr    <= wr_en;
            pwm_rd    <= 1'b0;
            if (wr_en) begin
                pwm_addr  <= wr_addr;
                pwm_d_out <= 32'(wr_data);
            end
            cmd_err   <= err_nxt;
            busy      <= busy_nxt;
            done      <= busy && !busy_nxt;
            cmd_ready <= (state_nxt != ST_INIT);
        end
    end

endmodule
